// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sap_pkg
//  Purpose  : Shared widths, opcodes and datapath enums for the SAP-1 core.
//  Revision : 1.0 - initial release
// ============================================================================
package sap_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  localparam logic [ADDR_W-1:0] OP_LDA = 4'h0;
  localparam logic [ADDR_W-1:0] OP_ADD = 4'h1;
  localparam logic [ADDR_W-1:0] OP_SUB = 4'h2;
  localparam logic [ADDR_W-1:0] OP_OUT = 4'hE;
  localparam logic [ADDR_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_CMP = 3'd5
  } alu_op_e;

  // Enumerated in descending bus priority after BUS_NONE.
  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_PC   = 3'd1,
    BUS_IR   = 3'd2,
    BUS_MEM  = 3'd3,
    BUS_ACC  = 3'd4,
    BUS_ALU  = 3'd5
  } bus_src_e;

endpackage
`default_nettype wire

// File: rtl/sap_alu.sv
`default_nettype none
// ============================================================================
//  Module   : sap_alu
//  Purpose  : Combinational SAP-1 ALU; carry=1 on sub/cmp means no borrow.
//  Revision : 1.0 - initial release
// ============================================================================
module sap_alu
  import sap_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum9;

  always_comb begin
    sum9 = '0;
    unique case (op_i)
      ALU_ADD:          sum9 = {1'b0, a_i} + {1'b0, b_i};
      ALU_SUB, ALU_CMP: sum9 = {1'b0, a_i} + {1'b0, ~b_i} + 9'd1;
      ALU_AND:          sum9 = {1'b0, a_i & b_i};
      ALU_OR:           sum9 = {1'b0, a_i | b_i};
      ALU_XOR:          sum9 = {1'b0, a_i ^ b_i};
      default:          sum9 = '0;
    endcase
  end

  assign result_o = sum9[DATA_W-1:0];
  assign carry_o  = sum9[DATA_W];
  assign zero_o   = (sum9[DATA_W-1:0] == '0);

endmodule
`default_nettype wire

// File: rtl/sap_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : sap_datapath
//  Purpose  : SAP-1 W-bus datapath (PC, MAR, RAM, IR, ACC, B, ALU, OUT).
//             Define DATAPATH_FLAGS_EN to implement the zero/carry flags.
//  Revision : 1.0 - initial release
// ============================================================================
module sap_datapath
  import sap_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              inc,
  input  logic              pc_out_en,
  input  logic              low_ld_mar,
  input  logic              low_mem_out_en,
  input  logic              low_ld_ir,
  input  logic              low_ir_out_en,
  input  logic              low_ld_acc,
  input  logic              acc_out_en,
  input  logic              sub_add,
  input  logic              and_ratna,
  input  logic              or_ratna,
  input  logic              xor_ratna,
  input  logic              cmp_ratna,
  input  logic              subadd_out_en,
  input  logic              low_ld_b_reg,
  input  logic              low_ld_out_reg,
  input  logic              low_halt,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [ADDR_W-1:0] op_code,
  output logic [DATA_W-1:0] out_reg,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              bus_conflict
);

  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, acc_q, acc_d, b_q, b_d, out_q, out_d;
  logic              conflict_q, conflict_d;
  logic [DATA_W-1:0] ram_q [2**ADDR_W];

  logic [DATA_W-1:0] bus, alu_result;
  logic              alu_zero, alu_carry;
  alu_op_e           alu_op;
  bus_src_e          bus_src;
  logic [2:0]        n_drivers;

  always_comb begin
    alu_op = ALU_ADD;
    if (cmp_ratna)      alu_op = ALU_CMP;
    else if (sub_add)   alu_op = ALU_SUB;
    else if (and_ratna) alu_op = ALU_AND;
    else if (or_ratna)  alu_op = ALU_OR;
    else if (xor_ratna) alu_op = ALU_XOR;
  end

  sap_alu u_alu (
    .a_i      (acc_q),
    .b_i      (b_q),
    .op_i     (alu_op),
    .result_o (alu_result),
    .zero_o   (alu_zero),
    .carry_o  (alu_carry)
  );

  always_comb begin
    bus_src = BUS_NONE;
    if (pc_out_en)            bus_src = BUS_PC;
    else if (!low_ir_out_en)  bus_src = BUS_IR;
    else if (!low_mem_out_en) bus_src = BUS_MEM;
    else if (acc_out_en)      bus_src = BUS_ACC;
    else if (subadd_out_en)   bus_src = BUS_ALU;
  end

  always_comb begin
    bus = '0;
    unique case (bus_src)
      BUS_PC:  bus = {4'h0, pc_q};
      BUS_IR:  bus = {4'h0, ir_q[ADDR_W-1:0]};
      BUS_MEM: bus = ram_q[mar_q];
      BUS_ACC: bus = acc_q;
      BUS_ALU: bus = alu_result;
      default: bus = '0;
    endcase
  end

  assign n_drivers = 3'(pc_out_en) + 3'(!low_ir_out_en) + 3'(!low_mem_out_en)
                   + 3'(acc_out_en) + 3'(subadd_out_en);

  always_comb begin
    pc_d       = inc             ? pc_q + 4'd1     : pc_q;
    mar_d      = !low_ld_mar     ? bus[ADDR_W-1:0] : mar_q;
    ir_d       = !low_ld_ir      ? bus             : ir_q;
    b_d        = !low_ld_b_reg   ? bus             : b_q;
    out_d      = !low_ld_out_reg ? bus             : out_q;
    acc_d      = (!low_ld_acc && alu_op != ALU_CMP) ? bus : acc_q;
    conflict_d = conflict_q | (n_drivers > 3'd1);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q       <= '0;
      mar_q      <= '0;
      ir_q       <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      out_q      <= '0;
      conflict_q <= 1'b0;
    end else if (low_halt) begin
      pc_q       <= pc_d;
      mar_q      <= mar_d;
      ir_q       <= ir_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      out_q      <= out_d;
      conflict_q <= conflict_d;
    end
  end

  // Program load port bypasses halt; the array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (prog_we) ram_q[prog_addr] <= prog_data;
  end

`ifdef DATAPATH_FLAGS_EN
  logic zero_q, zero_d, carry_q, carry_d;
  logic flag_upd;

  assign flag_upd = !low_ld_acc && subadd_out_en;

  always_comb begin
    zero_d  = flag_upd ? alu_zero  : zero_q;
    carry_d = flag_upd ? alu_carry : carry_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (low_halt) begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
`else
  logic unused_alu_flags;
  assign unused_alu_flags = alu_zero ^ alu_carry;
  assign zero_flag        = 1'b0;
  assign carry_flag       = 1'b0;
`endif

  assign op_code      = ir_q[DATA_W-1:ADDR_W];
  assign out_reg      = out_q;
  assign bus_conflict = conflict_q;

endmodule
`default_nettype wire

// File: doc/sap_datapath.md
# sap_datapath

Register-transfer datapath for the SAP-1 core, directly downstream of the control sequencer. It consumes the sequencer's control word each cycle and contains the program counter, MAR, 16x8 program/data RAM, instruction register, accumulator, B register, ALU and output register, all sharing one 8-bit W-bus. It returns the current opcode to the sequencer, closing the fetch/execute loop.

## Interface
- No parameters; widths are fixed by the shared package (8-bit data, 4-bit address/opcode).
- clk  in  1  system clock; all state updates on rising edge
- clr  in  1  reset, asynchronous, active-high
- inc  in  1  increment PC
- pc_out_en  in  1  PC drives bus
- low_ld_mar  in  1  load MAR from bus[3:0] (active-low)
- low_mem_out_en  in  1  RAM[MAR] drives bus (active-low)
- low_ld_ir  in  1  load IR from bus (active-low)
- low_ir_out_en  in  1  IR operand drives bus (active-low)
- low_ld_acc  in  1  load ACC (active-low)
- acc_out_en  in  1  ACC drives bus
- sub_add, and_ratna, or_ratna, xor_ratna, cmp_ratna  in  1 each  ALU operation selects
- subadd_out_en  in  1  ALU result drives bus
- low_ld_b_reg  in  1  load B from bus (active-low)
- low_ld_out_reg  in  1  load output register from bus (active-low)
- low_halt  in  1  halt (active-low); freezes all state
- prog_we  in  1  RAM program write strobe
- prog_addr  in  4  RAM program write address
- prog_data  in  8  RAM program write data
- op_code  out  4  IR[7:4], to sequencer
- out_reg  out  8  output register
- zero_flag, carry_flag  out  1 each  ALU flags
- bus_conflict  out  1  sticky: more than one bus driver seen

## Operation
- Bus: combinational mux. Sources: PC as {4'h0,pc}; IR operand as {4'h0,ir[3:0]}; RAM[MAR]; ACC; ALU result. No driver -> 8'h00. Multiple drivers -> priority PC > IR > MEM > ACC > ALU; bus_conflict sets and stays set until clr.
- PC: 4-bit; inc adds 1, wraps 15->0.
- Loads: each register loads the bus value on the edge where its load is active. MAR takes bus[3:0].
- ALU (combinational, A=ACC, B=B reg): select priority cmp > sub > and > or > xor > add (add when none set). Add: 9-bit A+B, carry = bit 8. Sub/cmp: A + ~B + 1, carry = 1 means no borrow. Logic ops: carry = 0.
- ACC source: the bus. For cmp, ACC load is suppressed even with low_ld_acc low; only flags update.
- Flags update when low_ld_acc=0 and subadd_out_en=1: zero = (result==0), carry as above. Flags hold otherwise.
- low_halt=0: no register, flag or PC updates; bus still driven. Program writes still permitted.
- RAM: asynchronous read at MAR; synchronous write on prog_we at prog_addr. Write to the address being read: bus shows old data that cycle, new data next cycle. RAM contents are not reset.

## Timing
- Reset values: PC, MAR, IR, ACC, B, out_reg = 0; op_code = 0; flags = 0; bus_conflict = 0.
- clr mid-instruction clears immediately (asynchronous), independent of clk; the RAM keeps its contents.
- op_code valid the cycle after the IR load edge.
- Register-to-bus-to-register transfer completes in one cycle. ALU result is valid the cycle after the B load.

## Configuration
- DATAPATH_FLAGS_EN defined: zero/carry flags implemented as above; cmp updates flags only.
- Not defined: zero_flag and carry_flag tied to 0, no flag registers; cmp performs no state update (ACC still suppressed).

## Structure
- Package sap_pkg: DATA_W=8, ADDR_W=4, opcode constants, ALU-op enum, bus-source enum with priority order.
- Sub-module sap_alu: combinational; takes ACC, B and ALU-op enum; returns result, zero and carry. Registers, RAM and bus mux stay in sap_datapath.

## Test plan
- clr asserted mid-cycle with ACC=8'h5A -> all registers 0 asynchronously; RAM preloaded value at addr 3 still readable afterward.
- Program RAM[0]=8'h0E, fetch (pc_out_en+ld_mar, then mem_out+ld_ir) -> op_code=4'h0, IR operand 4'hE, PC=1 after inc.
- ACC=8'h05, B=8'h07, sub_add, ALU->ACC -> ACC=8'hFE, carry=0, zero=0; ACC=8'h07 cmp B=8'h07 -> ACC unchanged, zero=1, carry=1.
- ACC=8'hF0, B=8'h20, add -> ACC=8'h10, carry=1; PC at 15 with inc -> 0.
- pc_out_en and acc_out_en together -> bus = PC value, bus_conflict=1 and held until clr.
- low_halt=0 with inc and low_ld_acc active -> PC and ACC unchanged; prog_we still writes RAM.
